rvh_l1d_req_arb: RTL and testbench
==================================

Name: rvh_l1d_req_arb

Overview:
- Arbitrates the load pipe, store pipe and PTW request sources onto the single L1D request port.
- Sequences atomics (LR/SC/AMO): once an atomic is granted, all sources are locked out until the L1D signals completion.
- Registered one-entry output stage; drives the per-source valid flags and opcodes consumed by the L1D request decoder.
- Sits between the LSU issue pipes / PTW and the L1D tag/data pipeline.

Parameters:
- PADDR_W, 56, physical address width
- DATA_W, 64, store data width
- ID_W, 8, request tag width (ROB/LSQ/PTW id)
- STARVE_MAX, 8, consecutive lost arbitration cycles before a waiting load is force-granted

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ld_req_vld_i  in  1  load request valid
- ld_req_rdy_o  out  1  load request accepted
- ld_req_opcode_i  in  LDU_OP_WIDTH  load opcode
- ld_req_paddr_i  in  PADDR_W  load address
- ld_req_id_i  in  ID_W  load tag
- st_req_vld_i  in  1  store/atomic request valid
- st_req_rdy_o  out  1  store request accepted
- st_req_opcode_i  in  STU_OP_WIDTH  store/atomic opcode
- st_req_paddr_i  in  PADDR_W  store address
- st_req_data_i  in  DATA_W  store/AMO operand
- st_req_id_i  in  ID_W  store tag
- ptw_req_vld_i  in  1  PTW load valid
- ptw_req_rdy_o  out  1  PTW request accepted
- ptw_req_paddr_i  in  PADDR_W  PTE address
- ptw_req_id_i  in  ID_W  PTW tag
- l1d_req_vld_o  out  1  output request valid
- l1d_req_rdy_i  in  1  L1D accepts output request
- l1d_is_ld_o / l1d_is_st_o / l1d_is_ptw_o  out  1 each  one-hot source of held request, to decoder
- l1d_ld_opcode_o  out  LDU_OP_WIDTH  held load opcode
- l1d_st_opcode_o  out  STU_OP_WIDTH  held store opcode
- l1d_paddr_o  out  PADDR_W  held address
- l1d_data_o  out  DATA_W  held store data
- l1d_id_o  out  ID_W  held tag
- atomic_done_i  in  1  L1D finished the outstanding atomic
- kill_ld_i  in  1  pipeline flush of speculative loads
- atomic_busy_o  out  1  atomic lock active

Behaviour:
- Reset (rst=0, async): all outputs 0, output register empty, FSM=IDLE, starvation counter=0.
- Output register: loads when empty or (l1d_req_vld_o & l1d_req_rdy_i) in the same cycle. Request-to-output latency is 1 cycle. Payload is held stable while vld & !rdy.
- Grant: at most one *_rdy_o per cycle. rdy_o is asserted only for the winner, only when the register can load, and only with FSM=IDLE. rdy_o is combinational from vld inputs and state; the source must hold its payload until rdy.
- Default priority: PTW > ST > LD.
- Starvation: the counter increments each cycle ld_req_vld_i=1 and the load loses while the register can load. At STARVE_MAX the load beats PTW and ST once. The counter clears on a load grant or when ld_req_vld_i=0. It saturates and never wraps.
- FSM IDLE -> ATOMIC: on a ST grant whose opcode is LR/SC/AMO. atomic_busy_o=1 from the next cycle.
- FSM ATOMIC: all rdy_o=0; an output already held still drains normally.
- FSM ATOMIC -> IDLE: on atomic_done_i. Grants are permitted again from the following cycle, not the same cycle.
- atomic_done_i in IDLE is ignored. An atomic grant in the same cycle as done cannot occur, because there are no grants in ATOMIC.
- kill_ld_i: if the held entry is a load, it is dropped (vld_o=0 next cycle) even if rdy_i=1 this cycle. A load offered that cycle gets rdy_o=0. The starvation counter clears. Held ST/PTW entries and the FSM are unaffected.
- Non-decodable ST opcode is still granted as a plain store (no lock).
- l1d_is_*_o are 0 when l1d_req_vld_o=0.

Decomposition:
- rvh_l1d_pkg: enum rvh_l1d_req_src_e {SRC_LD, SRC_ST, SRC_PTW}; function is_atomic_stu_op(opcode) covering STU_LRW/LRD/SCW/SCD and all STU_AMO*; typedef of the held request struct.
- Sub-module rvh_l1d_arb_starve_cnt (saturating counter with clear/inc and a force output).
- FSM and output register stay in the top module.

Test Plan:
- All three valid in one cycle, output idle: ptw_rdy=1 only; next cycle l1d_is_ptw_o=1, paddr=PTW addr. ST is granted the following cycle, LD after.
- ST stream continuous with LD waiting, STARVE_MAX=8: LD is granted on the 9th cycle of waiting; the counter reads 0 afterward.
- ST AMOADDD granted: atomic_busy_o=1 next cycle; ld/st/ptw rdy stay 0 for 20 cycles. atomic_done_i is pulsed at cycle 20; rdy resumes at cycle 21.
- Output held with l1d_req_rdy_i=0 for 5 cycles: payload and vld are stable, no new grant. rdy_i=1 with a pending LD gives back-to-back acceptance (throughput 1/cycle).
- Held LD plus kill_ld_i=1 with rdy_i=1: l1d_req_vld_o=0 next cycle and the same-cycle LD is not granted. Repeating with a held ST: ST is delivered.
- Assert rst=0 mid-ATOMIC with the output held: vld_o=0 and atomic_busy_o=0 immediately (async). After release, a fresh LD is granted normally.

Source files
------------

// File: rtl/rvh_l1d_req_arb_pkg.sv
// Shared types and opcode encodings for the L1D request arbiter.
// Held-request payload fields are sized for the default widths; instances may only narrow them.
package rvh_l1d_req_arb_pkg;

  localparam int LDU_OP_WIDTH = 4;
  localparam int STU_OP_WIDTH = 5;

  localparam int RVH_L1D_PADDR_MAX = 56;
  localparam int RVH_L1D_DATA_MAX  = 64;
  localparam int RVH_L1D_ID_MAX    = 8;

  localparam logic [LDU_OP_WIDTH-1:0] LDU_LB  = 4'd0;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LH  = 4'd1;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LW  = 4'd2;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LD  = 4'd3;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LBU = 4'd4;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LHU = 4'd5;
  localparam logic [LDU_OP_WIDTH-1:0] LDU_LWU = 4'd6;

  localparam logic [STU_OP_WIDTH-1:0] STU_SB       = 5'd0;
  localparam logic [STU_OP_WIDTH-1:0] STU_SH       = 5'd1;
  localparam logic [STU_OP_WIDTH-1:0] STU_SW       = 5'd2;
  localparam logic [STU_OP_WIDTH-1:0] STU_SD       = 5'd3;
  localparam logic [STU_OP_WIDTH-1:0] STU_LRW      = 5'd4;
  localparam logic [STU_OP_WIDTH-1:0] STU_LRD      = 5'd5;
  localparam logic [STU_OP_WIDTH-1:0] STU_SCW      = 5'd6;
  localparam logic [STU_OP_WIDTH-1:0] STU_SCD      = 5'd7;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPW = 5'd8;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAPD = 5'd9;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDW  = 5'd10;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOADDD  = 5'd11;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDW  = 5'd12;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOANDD  = 5'd13;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOORW   = 5'd14;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOORD   = 5'd15;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORW  = 5'd16;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOXORD  = 5'd17;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXW  = 5'd18;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXD  = 5'd19;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUW = 5'd20;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXUD = 5'd21;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINW  = 5'd22;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIND  = 5'd23;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUW = 5'd24;
  localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINUD = 5'd25;

  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_ST  = 2'd1,
    SRC_PTW = 2'd2
  } rvh_l1d_req_src_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ATOMIC = 1'b1
  } rvh_l1d_arb_state_e;

  typedef struct packed {
    rvh_l1d_req_src_e              src;
    logic [LDU_OP_WIDTH-1:0]       ld_op;
    logic [STU_OP_WIDTH-1:0]       st_op;
    logic [RVH_L1D_PADDR_MAX-1:0]  paddr;
    logic [RVH_L1D_DATA_MAX-1:0]   data;
    logic [RVH_L1D_ID_MAX-1:0]     id;
  } rvh_l1d_req_t;

  // LR, SC and every AMO occupy one contiguous block of the store opcode space.
  function automatic logic is_atomic_stu_op(input logic [STU_OP_WIDTH-1:0] op);
    return (op inside {[STU_LRW:STU_AMOMINUD]});
  endfunction

endpackage

// File: rtl/rvh_l1d_req_arb_if.sv
// Request-side and L1D-side handshake bundle for the L1D request arbiter.
interface rvh_l1d_req_arb_if #(
  parameter int PADDR_W = 56,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 8
) ();
  import rvh_l1d_req_arb_pkg::*;

  logic                    ld_req_vld;
  logic                    ld_req_rdy;
  logic [LDU_OP_WIDTH-1:0] ld_req_opcode;
  logic [PADDR_W-1:0]      ld_req_paddr;
  logic [ID_W-1:0]         ld_req_id;

  logic                    st_req_vld;
  logic                    st_req_rdy;
  logic [STU_OP_WIDTH-1:0] st_req_opcode;
  logic [PADDR_W-1:0]      st_req_paddr;
  logic [DATA_W-1:0]       st_req_data;
  logic [ID_W-1:0]         st_req_id;

  logic                    ptw_req_vld;
  logic                    ptw_req_rdy;
  logic [PADDR_W-1:0]      ptw_req_paddr;
  logic [ID_W-1:0]         ptw_req_id;

  logic                    l1d_req_vld;
  logic                    l1d_req_rdy;
  logic                    l1d_is_ld;
  logic                    l1d_is_st;
  logic                    l1d_is_ptw;
  logic [LDU_OP_WIDTH-1:0] l1d_ld_opcode;
  logic [STU_OP_WIDTH-1:0] l1d_st_opcode;
  logic [PADDR_W-1:0]      l1d_paddr;
  logic [DATA_W-1:0]       l1d_data;
  logic [ID_W-1:0]         l1d_id;

  logic                    atomic_done;
  logic                    kill_ld;
  logic                    atomic_busy;

  modport slave (
    input  ld_req_vld, ld_req_opcode, ld_req_paddr, ld_req_id,
    input  st_req_vld, st_req_opcode, st_req_paddr, st_req_data, st_req_id,
    input  ptw_req_vld, ptw_req_paddr, ptw_req_id,
    input  l1d_req_rdy, atomic_done, kill_ld,
    output ld_req_rdy, st_req_rdy, ptw_req_rdy,
    output l1d_req_vld, l1d_is_ld, l1d_is_st, l1d_is_ptw,
    output l1d_ld_opcode, l1d_st_opcode, l1d_paddr, l1d_data, l1d_id,
    output atomic_busy
  );

  modport master (
    output ld_req_vld, ld_req_opcode, ld_req_paddr, ld_req_id,
    output st_req_vld, st_req_opcode, st_req_paddr, st_req_data, st_req_id,
    output ptw_req_vld, ptw_req_paddr, ptw_req_id,
    output l1d_req_rdy, atomic_done, kill_ld,
    input  ld_req_rdy, st_req_rdy, ptw_req_rdy,
    input  l1d_req_vld, l1d_is_ld, l1d_is_st, l1d_is_ptw,
    input  l1d_ld_opcode, l1d_st_opcode, l1d_paddr, l1d_data, l1d_id,
    input  atomic_busy
  );

endinterface

// File: rtl/rvh_l1d_arb_starve_cnt.sv
// Saturating count of consecutive lost load arbitrations; starved forces one load win.
module rvh_l1d_arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign starved = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/rvh_l1d_req_arb.sv
// Arbitrates LD / ST / PTW onto the L1D request port through a one-entry output register.
// state      | meaning
// ARB_IDLE   | normal arbitration, grants allowed
// ARB_ATOMIC | atomic in flight, all grants blocked until atomic_done
module rvh_l1d_req_arb
  import rvh_l1d_req_arb_pkg::*;
#(
  parameter int unsigned PADDR_W    = 56,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst,
  rvh_l1d_req_arb_if.slave bus
);

  rvh_l1d_arb_state_e state_q, state_d;
  rvh_l1d_req_t       held_q, held_d;
  logic               held_vld_q, held_vld_d;

  logic can_load;
  logic ld_ok;
  logic starved;
  logic gnt_ld, gnt_st, gnt_ptw;
  logic starve_inc, starve_clr;

  assign can_load = !held_vld_q || bus.l1d_req_rdy;
  assign ld_ok    = bus.ld_req_vld && !bus.kill_ld;

  always_comb begin
    state_d = state_q;
    gnt_ld  = 1'b0;
    gnt_st  = 1'b0;
    gnt_ptw = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (can_load) begin
          if (ld_ok && starved) begin
            gnt_ld = 1'b1;
          end else if (bus.ptw_req_vld) begin
            gnt_ptw = 1'b1;
          end else if (bus.st_req_vld) begin
            gnt_st = 1'b1;
          end else if (ld_ok) begin
            gnt_ld = 1'b1;
          end
        end
        if (gnt_st && is_atomic_stu_op(bus.st_req_opcode)) begin
          state_d = ARB_ATOMIC;
        end
      end
      ARB_ATOMIC: begin
        if (bus.atomic_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign starve_clr = !bus.ld_req_vld || bus.kill_ld || gnt_ld;
  assign starve_inc = bus.ld_req_vld && !gnt_ld && can_load && (state_q == ARB_IDLE);

  rvh_l1d_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (starve_clr),
    .inc     (starve_inc),
    .starved (starved)
  );

  // A new grant replaces the entry; otherwise it leaves on acceptance or on a load flush.
  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (gnt_ld || gnt_st || gnt_ptw) begin
      held_vld_d = 1'b1;
      held_d     = '0;
      if (gnt_ld) begin
        held_d.src   = SRC_LD;
        held_d.ld_op = bus.ld_req_opcode;
        held_d.paddr = RVH_L1D_PADDR_MAX'(bus.ld_req_paddr);
        held_d.id    = RVH_L1D_ID_MAX'(bus.ld_req_id);
      end else if (gnt_st) begin
        held_d.src   = SRC_ST;
        held_d.st_op = bus.st_req_opcode;
        held_d.paddr = RVH_L1D_PADDR_MAX'(bus.st_req_paddr);
        held_d.data  = RVH_L1D_DATA_MAX'(bus.st_req_data);
        held_d.id    = RVH_L1D_ID_MAX'(bus.st_req_id);
      end else begin
        held_d.src   = SRC_PTW;
        held_d.ld_op = LDU_LD;
        held_d.paddr = RVH_L1D_PADDR_MAX'(bus.ptw_req_paddr);
        held_d.id    = RVH_L1D_ID_MAX'(bus.ptw_req_id);
      end
    end else if (held_vld_q &&
                 (bus.l1d_req_rdy || (bus.kill_ld && (held_q.src == SRC_LD)))) begin
      held_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_vld_q <= 1'b0;
      held_q     <= '0;
    end else begin
      held_vld_q <= held_vld_d;
      held_q     <= held_d;
    end
  end

  assign bus.ld_req_rdy    = gnt_ld;
  assign bus.st_req_rdy    = gnt_st;
  assign bus.ptw_req_rdy   = gnt_ptw;

  assign bus.l1d_req_vld   = held_vld_q;
  assign bus.l1d_is_ld     = held_vld_q && (held_q.src == SRC_LD);
  assign bus.l1d_is_st     = held_vld_q && (held_q.src == SRC_ST);
  assign bus.l1d_is_ptw    = held_vld_q && (held_q.src == SRC_PTW);
  assign bus.l1d_ld_opcode = held_q.ld_op;
  assign bus.l1d_st_opcode = held_q.st_op;
  assign bus.l1d_paddr     = held_q.paddr[PADDR_W-1:0];
  assign bus.l1d_data      = held_q.data[DATA_W-1:0];
  assign bus.l1d_id        = held_q.id[ID_W-1:0];
  assign bus.atomic_busy   = (state_q == ARB_ATOMIC);

endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Randomized bench for rvh_l1d_req_arb against a transaction-level reference model.
module tb_rvh_l1d_req_arb;
  import rvh_l1d_req_arb_pkg::*;

  localparam int PADDR_W    = 56;
  localparam int DATA_W     = 64;
  localparam int ID_W       = 8;
  localparam int STARVE_MAX = 8;

  localparam int G_NONE = 0;
  localparam int G_LD   = 1;
  localparam int G_ST   = 2;
  localparam int G_PTW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvh_l1d_req_arb_if #(.PADDR_W(PADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  rvh_l1d_req_arb #(
    .PADDR_W    (PADDR_W),
    .DATA_W     (DATA_W),
    .ID_W       (ID_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                      src;
    logic [LDU_OP_WIDTH-1:0] ld_op;
    logic [STU_OP_WIDTH-1:0] st_op;
    logic [PADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]       data;
    logic [ID_W-1:0]         id;
  } req_t;

  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  req_t held_q[$];
  bit   lock;
  int   lost;

  // source-side pending requests
  bit   ld_pend, st_pend, ptw_pend;
  req_t ld_r, st_r, ptw_r;

  int p_ld, p_st, p_ptw, p_rdy, p_kill, p_done, p_atomic, p_bad;
  int last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_amo(input logic [STU_OP_WIDTH-1:0] op);
    return (op >= STU_LRW) && (op <= STU_AMOMINUD);
  endfunction

  function automatic req_t rand_req(input int src);
    req_t r;
    logic [63:0] a, d;
    int   sel;
    a = {$urandom, $urandom};
    d = {$urandom, $urandom};
    r.src   = src;
    r.paddr = a[PADDR_W-1:0];
    r.data  = d;
    r.id    = ID_W'($urandom);
    r.ld_op = LDU_OP_WIDTH'($urandom_range(0, 6));
    sel     = int'($urandom_range(0, 99));
    if (sel < p_atomic)
      r.st_op = STU_OP_WIDTH'($urandom_range(int'(STU_LRW), int'(STU_AMOMINUD)));
    else if (sel < p_atomic + p_bad)
      r.st_op = STU_OP_WIDTH'($urandom_range(26, 31));
    else
      r.st_op = STU_OP_WIDTH'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic check_outputs();
    req_t h;
    chk("vld", 64'(bus.l1d_req_vld), 64'(held_q.size() != 0));
    chk("busy", 64'(bus.atomic_busy), 64'(lock));
    if (held_q.size() == 0) begin
      chk("is_idle", 64'({bus.l1d_is_ld, bus.l1d_is_st, bus.l1d_is_ptw}), 64'(0));
    end else begin
      h = held_q[0];
      chk("is_src", 64'({bus.l1d_is_ld, bus.l1d_is_st, bus.l1d_is_ptw}),
          64'({h.src == G_LD, h.src == G_ST, h.src == G_PTW}));
      chk("paddr", 64'(bus.l1d_paddr), 64'(h.paddr));
      chk("id", 64'(bus.l1d_id), 64'(h.id));
      if (h.src == G_LD) chk("ld_op", 64'(bus.l1d_ld_opcode), 64'(h.ld_op));
      if (h.src == G_ST) begin
        chk("st_op", 64'(bus.l1d_st_opcode), 64'(h.st_op));
        chk("data", bus.l1d_data, h.data);
      end
    end
  endtask

  // One clock: check registered outputs, drive inputs, check grants, advance the model.
  task automatic step();
    int gnt;
    bit can_take, ld_ok, kill, l1d_rdy, done;
    @(negedge clk);
    check_outputs();
    if (!ld_pend && int'($urandom_range(0, 99)) < p_ld) begin ld_pend = 1; ld_r = rand_req(G_LD); end
    if (!st_pend && int'($urandom_range(0, 99)) < p_st) begin st_pend = 1; st_r = rand_req(G_ST); end
    if (!ptw_pend && int'($urandom_range(0, 99)) < p_ptw) begin ptw_pend = 1; ptw_r = rand_req(G_PTW); end
    l1d_rdy = int'($urandom_range(0, 99)) < p_rdy;
    kill    = int'($urandom_range(0, 99)) < p_kill;
    done    = int'($urandom_range(0, 99)) < p_done;

    bus.ld_req_vld    = ld_pend;
    bus.ld_req_opcode = ld_r.ld_op;
    bus.ld_req_paddr  = ld_r.paddr;
    bus.ld_req_id     = ld_r.id;
    bus.st_req_vld    = st_pend;
    bus.st_req_opcode = st_r.st_op;
    bus.st_req_paddr  = st_r.paddr;
    bus.st_req_data   = st_r.data;
    bus.st_req_id     = st_r.id;
    bus.ptw_req_vld   = ptw_pend;
    bus.ptw_req_paddr = ptw_r.paddr;
    bus.ptw_req_id    = ptw_r.id;
    bus.l1d_req_rdy   = l1d_rdy;
    bus.kill_ld       = kill;
    bus.atomic_done   = done;
    #1;

    can_take = (held_q.size() == 0) || l1d_rdy;
    ld_ok    = ld_pend && !kill;
    gnt      = G_NONE;
    if (!lock && can_take) begin
      if (ld_ok && lost >= STARVE_MAX) gnt = G_LD;
      else if (ptw_pend)               gnt = G_PTW;
      else if (st_pend)                gnt = G_ST;
      else if (ld_ok)                  gnt = G_LD;
    end
    chk("ld_rdy",  64'(bus.ld_req_rdy),  64'(gnt == G_LD));
    chk("st_rdy",  64'(bus.st_req_rdy),  64'(gnt == G_ST));
    chk("ptw_rdy", 64'(bus.ptw_req_rdy), 64'(gnt == G_PTW));

    if (bus.ld_req_rdy)       last_gnt = G_LD;
    else if (bus.st_req_rdy)  last_gnt = G_ST;
    else if (bus.ptw_req_rdy) last_gnt = G_PTW;
    else                      last_gnt = G_NONE;

    if (!ld_pend || kill || gnt == G_LD) lost = 0;
    else if (!lock && can_take && lost < STARVE_MAX) lost++;

    if (gnt != G_NONE) begin
      held_q.delete();
      case (gnt)
        G_LD:    held_q.push_back(ld_r);
        G_ST:    held_q.push_back(st_r);
        default: held_q.push_back(ptw_r);
      endcase
    end else if (held_q.size() != 0 && (l1d_rdy || (kill && held_q[0].src == G_LD))) begin
      held_q.delete();
    end

    if (lock && done) lock = 0;
    else if (gnt == G_ST && is_amo(st_r.st_op)) lock = 1;

    if (gnt == G_LD)  ld_pend  = 0;
    if (gnt == G_ST)  st_pend  = 0;
    if (gnt == G_PTW) ptw_pend = 0;
  endtask

  task automatic set_knobs(input int ld, input int st, input int ptw, input int rdy,
                           input int kill, input int done, input int amo, input int bad);
    p_ld = ld; p_st = st; p_ptw = ptw; p_rdy = rdy;
    p_kill = kill; p_done = done; p_atomic = amo; p_bad = bad;
  endtask

  task automatic drain(input int n);
    set_knobs(0, 0, 0, 100, 0, 100, 0, 0);
    for (int i = 0; i < n; i++) step();
    p_done = 0;
  endtask

  task automatic drive_idle_inputs();
    bus.ld_req_vld = 0; bus.st_req_vld = 0; bus.ptw_req_vld = 0;
    bus.l1d_req_rdy = 0; bus.kill_ld = 0; bus.atomic_done = 0;
    bus.ld_req_opcode = '0; bus.ld_req_paddr = '0; bus.ld_req_id = '0;
    bus.st_req_opcode = '0; bus.st_req_paddr = '0; bus.st_req_data = '0; bus.st_req_id = '0;
    bus.ptw_req_paddr = '0; bus.ptw_req_id = '0;
  endtask

  initial begin
    int n;
    drive_idle_inputs();
    lock = 0; lost = 0; ld_pend = 0; st_pend = 0; ptw_pend = 0;
    set_knobs(0, 0, 0, 100, 0, 0, 0, 0);
    ld_r = rand_req(G_LD); st_r = rand_req(G_ST); ptw_r = rand_req(G_PTW);

    #2;
    chk("rst_vld", 64'(bus.l1d_req_vld), 64'(0));
    chk("rst_busy", 64'(bus.atomic_busy), 64'(0));
    chk("rst_paddr", 64'(bus.l1d_paddr), 64'(0));
    chk("rst_rdy", 64'({bus.ld_req_rdy, bus.st_req_rdy, bus.ptw_req_rdy}), 64'(0));
    #10 rst = 1'b1;

    // all three sources at once: PTW, then ST, then LD
    step();
    ld_pend = 1; ld_r = rand_req(G_LD);
    st_pend = 1; st_r = rand_req(G_ST);
    ptw_pend = 1; ptw_r = rand_req(G_PTW);
    step(); chk("order_ptw", 64'(last_gnt), 64'(G_PTW));
    step(); chk("order_st",  64'(last_gnt), 64'(G_ST));
    step(); chk("order_ld",  64'(last_gnt), 64'(G_LD));
    drain(3);

    // continuous store stream starves a waiting load
    set_knobs(100, 100, 0, 100, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (last_gnt != G_LD && n < 40);
      chk("starve_wait", 64'(n), 64'(STARVE_MAX + 1));
    end
    drain(6);

    // AMOADDD locks the port until atomic_done
    set_knobs(100, 0, 0, 100, 0, 0, 0, 0);
    st_pend = 1; st_r = rand_req(G_ST); st_r.st_op = STU_AMOADDD;
    step(); chk("amo_gnt", 64'(last_gnt), 64'(G_ST));
    set_knobs(100, 100, 100, 100, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      step(); chk("amo_lock", 64'(last_gnt), 64'(G_NONE));
    end
    p_done = 100;
    step(); chk("amo_done_cyc", 64'(last_gnt), 64'(G_NONE));
    p_done = 0;
    step(); chk("amo_resume", 64'(last_gnt), 64'(G_PTW));
    drain(6);

    // output stall then back-to-back loads
    set_knobs(100, 0, 0, 0, 0, 0, 0, 0);
    step(); chk("hold_gnt", 64'(last_gnt), 64'(G_LD));
    for (int i = 0; i < 5; i++) begin
      step(); chk("hold_nogrant", 64'(last_gnt), 64'(G_NONE));
    end
    p_rdy = 100;
    for (int i = 0; i < 6; i++) begin
      step(); chk("b2b_ld", 64'(last_gnt), 64'(G_LD));
    end
    drain(4);

    // kill drops a held load, not a held store
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
    ld_pend = 1; ld_r = rand_req(G_LD);
    step();
    set_knobs(100, 0, 0, 100, 100, 0, 0, 0);
    step(); chk("kill_nogrant", 64'(last_gnt), 64'(G_NONE));
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
    ld_pend = 0;
    step();
    st_pend = 1; st_r = rand_req(G_ST);
    step(); chk("kill_st_gnt", 64'(last_gnt), 64'(G_ST));
    set_knobs(0, 0, 0, 100, 100, 0, 0, 0);
    step();
    drain(3);

    // randomized traffic, two mixes
    set_knobs(50, 40, 20, 70, 5, 10, 15, 5);
    for (int i = 0; i < 3000; i++) step();
    set_knobs(70, 80, 50, 90, 2, 15, 10, 5);
    for (int i = 0; i < 2000; i++) step();
    drain(8);

    // async reset in the middle of an atomic with the output held
    set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
    st_pend = 1; st_r = rand_req(G_ST); st_r.st_op = STU_AMOSWAPD;
    step(); step(); step();
    @(negedge clk);
    #3;
    drive_idle_inputs();
    rst = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.l1d_req_vld), 64'(0));
    chk("arst_busy", 64'(bus.atomic_busy), 64'(0));
    chk("arst_is_st", 64'(bus.l1d_is_st), 64'(0));
    held_q.delete(); lock = 0; lost = 0;
    ld_pend = 0; st_pend = 0; ptw_pend = 0;
    #4 rst = 1'b1;
    set_knobs(0, 0, 0, 100, 0, 0, 0, 0);
    ld_pend = 1; ld_r = rand_req(G_LD);
    step(); chk("post_rst_ld", 64'(last_gnt), 64'(G_LD));
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
